// File: rtl/cx_requant.sv
// Complex requantizer: convergent rounding by IN_F-OUT_F bits, then saturation to OUT_W bits,
// in a two-stage valid/ready pipeline with a sticky overflow flag and saturating overflow counter.
module cx_requant #(
  parameter int IN_W  = 24,
  parameter int IN_F  = 21,
  parameter int OUT_W = 8,
  parameter int OUT_F = 7,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  in_re,
  input  logic signed [IN_W-1:0]  in_im,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    ovf_clr,
  output logic                    ovf_sticky,
  output logic [CNT_W-1:0]        ovf_cnt
);

  localparam int S  = IN_F - OUT_F;
  localparam int RW = IN_W - S + 1;
  localparam int HW = RW - OUT_W + 1;

  generate
    if ((IN_F < OUT_F) || ((IN_W - IN_F) < (OUT_W - OUT_F))) begin : g_bad_params
      $error("cx_requant: parameters need IN_F >= OUT_F and IN_W-IN_F >= OUT_W-OUT_F");
    end
  endgenerate

  logic signed [IN_W-1:0]  in_cx   [2];
  logic signed [RW-1:0]    rnd     [2];
  logic signed [RW-1:0]    s1_cx_reg [2];
  logic signed [OUT_W-1:0] sat_val [2];
  logic                    sat_flag [2];

  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s2_ovf_reg;
  logic signed [OUT_W-1:0] out_re_reg;
  logic signed [OUT_W-1:0] out_im_reg;
  logic                    ovf_sticky_reg;
  logic                    ovf_sticky_next;
  logic [CNT_W-1:0]        ovf_cnt_reg;
  logic [CNT_W-1:0]        ovf_cnt_next;

  logic s1_adv;
  logic s2_adv;
  logic ovf_xfer;

  assign in_cx[0] = in_re;
  assign in_cx[1] = in_im;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_comp
      if (S == 0) begin : g_pass
        assign rnd[gi] = {in_cx[gi][IN_W-1], in_cx[gi]};
      end else begin : g_round
        logic signed [IN_W-S-1:0] trunc;
        logic [S-1:0]             frac;
        logic [S-1:0]             half;
        logic                     round_up;

        assign trunc = in_cx[gi][IN_W-1:S];
        assign frac  = in_cx[gi][S-1:0];

        always_comb begin
          half        = '0;
          half[S-1]   = 1'b1;
        end

        // Ties go to the even neighbour; the extra MSB absorbs the rounding carry.
        assign round_up = (frac > half) || ((frac == half) && trunc[0]);
        assign rnd[gi]  = {trunc[IN_W-S-1], trunc} + {{(RW-1){1'b0}}, round_up};
      end

      // Saturate when the bits above the output sign are not a pure sign extension.
      logic [HW-1:0] hi;
      logic          pos_ovf;
      logic          neg_ovf;

      assign hi      = s1_cx_reg[gi][RW-1:OUT_W-1];
      assign pos_ovf = !hi[HW-1] && (|hi);
      assign neg_ovf = hi[HW-1] && !(&hi);

      always_comb begin
        sat_val[gi]  = s1_cx_reg[gi][OUT_W-1:0];
        sat_flag[gi] = pos_ovf || neg_ovf;
        if (pos_ovf) begin
          sat_val[gi] = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (neg_ovf) begin
          sat_val[gi] = {1'b1, {(OUT_W-1){1'b0}}};
        end
      end
    end
  endgenerate

  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s2_ovf_reg   <= 1'b0;
      s1_cx_reg[0] <= '0;
      s1_cx_reg[1] <= '0;
      out_re_reg   <= '0;
      out_im_reg   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_reg <= in_valid;
        if (in_valid) begin
          s1_cx_reg[0] <= rnd[0];
          s1_cx_reg[1] <= rnd[1];
        end
      end
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_re_reg <= sat_val[0];
          out_im_reg <= sat_val[1];
          s2_ovf_reg <= sat_flag[0] || sat_flag[1];
        end
      end
    end
  end

  // Overflow accounting happens when a flagged word actually leaves; clear wins.
  assign ovf_xfer = s2_valid_reg && out_ready && s2_ovf_reg;

  always_comb begin
    ovf_sticky_next = ovf_sticky_reg;
    ovf_cnt_next    = ovf_cnt_reg;
    if (ovf_clr) begin
      ovf_sticky_next = 1'b0;
      ovf_cnt_next    = '0;
    end else if (ovf_xfer) begin
      ovf_sticky_next = 1'b1;
      if (!(&ovf_cnt_reg)) begin
        ovf_cnt_next = ovf_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky_reg <= 1'b0;
      ovf_cnt_reg    <= '0;
    end else begin
      ovf_sticky_reg <= ovf_sticky_next;
      ovf_cnt_reg    <= ovf_cnt_next;
    end
  end

  assign out_valid  = s2_valid_reg;
  assign out_re     = out_re_reg;
  assign out_im     = out_im_reg;
  assign ovf_sticky = ovf_sticky_reg;
  assign ovf_cnt    = ovf_cnt_reg;

endmodule

// File: tb/tb_cx_requant.sv
// Directed bench for cx_requant: scoreboard of expected words built from an independent
// real-valued rounding model, plus overflow counter/sticky model and hold-while-stalled checks.
module tb_cx_requant;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] in_re, in_im;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [7:0]  out_re, out_im, out_re2, out_im2;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic        ovf_clr;
  logic        ovf_sticky, ovf_sticky2;
  logic [15:0] ovf_cnt;
  logic [1:0]  ovf_cnt2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit rand_mode = 0;
  bit lat_chk   = 0;

  typedef struct {
    logic [7:0] re;
    logic [7:0] im;
    bit         ovf;
    int         cyc;
  } exp_t;
  exp_t sbq[$];

  int  exp_cnt, exp_cnt2;
  bit  exp_sticky;
  bit  prev_stall;
  logic [7:0] prev_re, prev_im;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cx_requant u_dut (
    .clk(clk), .rst(rst), .in_re(in_re), .in_im(in_im), .in_valid(in_valid),
    .in_ready(in_ready), .out_re(out_re), .out_im(out_im), .out_valid(out_valid),
    .out_ready(out_ready), .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky), .ovf_cnt(ovf_cnt)
  );

  cx_requant #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_re(in_re), .in_im(in_im), .in_valid(in_valid),
    .in_ready(in_ready2), .out_re(out_re2), .out_im(out_im2), .out_valid(out_valid2),
    .out_ready(out_ready), .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky2), .ovf_cnt(ovf_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Q2.21 -> Q0.7: value in output LSBs, ties to even, clamp to 8-bit range.
  function automatic void rq(input logic [23:0] x, output logic [7:0] y, output bit sat);
    int     xi;
    real    v, f;
    longint r;
    xi = int'($signed(x));
    v  = real'(xi) / 16384.0;
    f  = $floor(v);
    r  = longint'(f);
    if (v - f > 0.5) r++;
    else if ((v - f == 0.5) && r[0]) r++;
    sat = 1'b0;
    if (r > 127) begin r = 127; sat = 1'b1; end
    else if (r < -128) begin r = -128; sat = 1'b1; end
    y = r[7:0];
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    exp_t e;
    bit   s_re, s_im;
    if (rst) begin
      sbq.delete();
      exp_sticky = 0; exp_cnt = 0; exp_cnt2 = 0; prev_stall = 0;
    end else begin
      chk("ovf_sticky", 32'(ovf_sticky), 32'(exp_sticky));
      chk("ovf_cnt", 32'(ovf_cnt), exp_cnt);
      chk("ovf_cnt_w2", 32'(ovf_cnt2), exp_cnt2);
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_re", 32'(out_re), 32'(prev_re));
        chk("hold_im", 32'(out_im), 32'(prev_im));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out", sbq.size(), 1);
        end else begin
          e = sbq.pop_front();
          $display("out re=%0d im=%0d sat=%0d cyc=%0d", $signed(out_re), $signed(out_im), e.ovf, cyc);
          chk("out_re", 32'(out_re), 32'(e.re));
          chk("out_im", 32'(out_im), 32'(e.im));
          chk("out_re_w2", 32'(out_re2), 32'(e.re));
          if (lat_chk) chk("latency", cyc - e.cyc, 2);
          if (e.ovf) begin
            exp_sticky = 1;
            if (exp_cnt < 65535) exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
          end
        end
      end
      if (ovf_clr) begin
        exp_sticky = 0; exp_cnt = 0; exp_cnt2 = 0;
      end
      if (in_valid && in_ready) begin
        rq(in_re, e.re, s_re);
        rq(in_im, e.im, s_im);
        e.ovf = s_re || s_im;
        e.cyc = cyc;
        sbq.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_re = out_re;
      prev_im = out_im;
    end
  end

  task automatic send(input logic [23:0] re, input logic [23:0] im);
    bit acc;
    int n;
    n = 0;
    in_re = re; in_im = im; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 32'(acc), 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", sbq.size(), 0);
  endtask

  initial begin
    int acc;
    bit nxt;
    rst = 1; in_valid = 0; in_re = 0; in_im = 0; out_ready = 1; ovf_clr = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_re", 32'(out_re), 0);
    chk("rst_out_im", 32'(out_im), 0);
    chk("rst_sticky", 32'(ovf_sticky), 0);
    chk("rst_cnt", 32'(ovf_cnt), 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Rounding basics, back-to-back with fixed latency
    lat_chk = 1;
    send(24'h004000, 24'h0);
    send(24'h002000, 24'h0);
    send(24'h006000, 24'h0);
    send(24'hFFE000, 24'h0);
    wait_drain();
    lat_chk = 0;
    @(negedge clk);
    chk("basic_cnt", 32'(ovf_cnt), 0);
    @(posedge clk); #1;

    // Saturation, including rounding carry into overflow
    send(24'h7FFFFF, 24'h800000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sat_re", 32'(out_re), 32'h7F);
    chk("sat_im", 32'(out_im), 32'h80);
    wait_drain();
    @(negedge clk);
    chk("sat_sticky", 32'(ovf_sticky), 1);
    chk("sat_cnt1", 32'(ovf_cnt), 1);
    @(posedge clk); #1;
    send(24'h1FE000, 24'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("carry_re", 32'(out_re), 32'h7F);
    wait_drain();
    @(negedge clk);
    chk("sat_cnt2", 32'(ovf_cnt), 2);
    @(posedge clk); #1;

    // Random backpressure stream
    rand_mode = 1;
    for (int i = 0; i < 20; i++) send(24'(i * 7168 - 40000), 24'(50000 - i * 9000));
    wait_drain();
    rand_mode = 0;
    out_ready = 1;
    @(posedge clk); #1;

    // Full stall: pipeline fills with exactly two words
    out_ready = 0;
    in_re = 24'h010000; in_im = 24'h020000; in_valid = 1;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      nxt = in_valid && in_ready;
      if (nxt) acc++;
      @(posedge clk); #1;
      if (nxt) in_re = in_re + 24'h004000;
    end
    chk("stall_accepted", acc, 2);
    @(negedge clk);
    chk("stall_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 1;
    wait_drain();

    // Counter saturation at CNT_W=2 and clear-over-increment priority
    ovf_clr = 1;
    @(posedge clk); #1 ovf_clr = 0;
    for (int i = 0; i < 5; i++) send(24'h7FFFFF, 24'h0);
    wait_drain();
    @(negedge clk);
    chk("cnt_w2_sat", 32'(ovf_cnt2), 3);
    chk("cnt16_five", 32'(ovf_cnt), 5);
    @(posedge clk); #1;
    send(24'h800000, 24'h0);
    @(posedge clk); #1 ovf_clr = 1;
    @(negedge clk);
    chk("clr_same_cycle_valid", 32'(out_valid), 1);
    @(posedge clk); #1 ovf_clr = 0;
    @(negedge clk);
    chk("clr_cnt_w2", 32'(ovf_cnt2), 0);
    chk("clr_cnt16", 32'(ovf_cnt), 0);
    chk("clr_sticky", 32'(ovf_sticky), 0);
    @(posedge clk); #1;

    // Reset with words in flight
    out_ready = 0;
    send(24'h00C000, 24'h0);
    send(24'h010000, 24'h0);
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_flush_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    rst = 0; out_ready = 1;
    @(negedge clk);
    chk("rst_flush_in_ready", 32'(in_ready), 1);
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_flush_idle", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cx_requant.md
CX_REQUANT -- requirements
Module: cx_requant

Interface
REQ-001 Parameter IN_W, default 24, meaning: input word width of the complex multiply-add result (WIDTH+PHASE_WIDTH+1).
REQ-002 Parameter IN_F, default 21, meaning: input fractional bits.
REQ-003 Parameter OUT_W, default 8, meaning: output sample width.
REQ-004 Parameter OUT_F, default 7, meaning: output fractional bits.
REQ-005 Parameter CNT_W, default 16, meaning: overflow counter width.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 in_re, in_im  input  IN_W each  signed two's-complement multiply-add result.
REQ-009 in_valid  input  1  input word present.
REQ-010 in_ready  output  1  block can accept; transfer occurs when in_valid && in_ready.
REQ-011 out_re, out_im  output  OUT_W each  signed requantized sample.
REQ-012 out_valid  output  1  output word present.
REQ-013 out_ready  input  1  downstream accepts; transfer occurs when out_valid && out_ready.
REQ-014 ovf_clr  input  1  clears ovf_sticky and ovf_cnt.
REQ-015 ovf_sticky  output  1  set by any saturation since last clear/reset.
REQ-016 ovf_cnt  output  CNT_W  count of transferred words with saturation on re or im.

Function
REQ-017 Elaboration SHALL fail with a message unless IN_F >= OUT_F and (IN_W-IN_F) >= (OUT_W-OUT_F).
REQ-018 Shift S = IN_F-OUT_F; stage 1 SHALL compute convergent rounding (round half to even) of each component by S bits into IN_W-S+1 bits, with no intermediate wrap.
REQ-019 S = 0 SHALL pass values unrounded.
REQ-020 Stage 2 SHALL saturate each rounded component to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-021 Rounding carry into overflow (e.g. +127.5 LSB) SHALL saturate to +max, not wrap.
REQ-022 Pipeline SHALL be two registered stages, each with its own valid bit; latency from accepted input to out_valid is exactly 2 cycles when out_ready stays high.
REQ-023 Stage 2 advances when !s2_valid || out_ready; stage 1 advances when !s1_valid || stage 2 advances.
REQ-024 in_ready = !s1_valid || stage-1 advance (combinational from out_ready permitted).
REQ-025 Full throughput: one word per cycle while in_valid and out_ready are held high.
REQ-026 While out_valid && !out_ready, out_re/out_im/out_valid SHALL hold stable; no word dropped or duplicated.
REQ-027 Data order SHALL be preserved; re and im always travel together.
REQ-028 A word's saturation flag (re OR im) SHALL travel with it; ovf_cnt increments and ovf_sticky sets on output transfer of a flagged word.
REQ-029 ovf_cnt SHALL saturate at 2^CNT_W-1, not wrap.
REQ-030 ovf_clr SHALL take priority over a same-cycle increment: result 0 / sticky 0.
REQ-031 Simultaneous input accept and output transfer in a full pipeline SHALL be lossless.

Reset
REQ-032 On rst: s1_valid=0, s2_valid=0, out_valid=0, out_re=0, out_im=0, ovf_sticky=0, ovf_cnt=0.
REQ-033 in_ready SHALL be 1 in the cycle following reset deassertion.
REQ-034 rst asserted mid-stream SHALL discard all in-flight words; no output transfer results from them.

Verification
REQ-035 Defaults, out_ready=1, in_re = 0x004000, 0x002000, 0x006000, 0xFFE000 on consecutive cycles -> out_re = 1, 0, 2, 0 exactly 2 cycles after each; ovf_cnt=0.
REQ-036 in_re = 0x7FFFFF, in_im = 0x800000 -> out_re=127, out_im=-128, ovf_sticky=1, ovf_cnt=1; in_re = 0x1FE000 (127.5 LSB) -> 127, ovf_cnt=2.
REQ-037 Stream 20 incrementing words, out_ready toggled by random pattern -> output sequence identical and in order, outputs stable while stalled, no word lost.
REQ-038 out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 words accepted, in_ready=0 thereafter; releasing out_ready drains both in order.
REQ-039 CNT_W=2, 5 saturating words -> ovf_cnt stops at 3; ovf_clr in same cycle as a 6th saturating transfer -> ovf_cnt=0, ovf_sticky=0.
REQ-040 rst pulsed with 2 words in flight -> out_valid=0 next cycle, neither word ever appears, in_ready=1 after release.
